// File: rtl/fold_pkg.sv
// Shared types and helpers for the column fold remover.
// Pure declarations: no state, no latency.
// No flow control lives here.
package fold_pkg;

  // Widest sample the difference/abs helper is sized for.
  localparam int MAX_W      = 32;
  localparam int PKG_DATA_W = 16;

  typedef logic signed [PKG_DATA_W-1:0] sample_t;
  typedef logic signed [PKG_DATA_W:0]   diff_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN_CLEAR = 2'd1,
    SCAN_FOLD  = 2'd2
  } scan_state_e;

  // Magnitude of a sign-extended difference; the unsigned result keeps the
  // full range, so the most negative input still yields its true magnitude.
  function automatic logic [MAX_W:0] abs_diff(input logic signed [MAX_W:0] d);
    logic [MAX_W:0] u;
    u = d;
    if (d[MAX_W]) begin
      u = ~u + (MAX_W+1)'(1);
    end
    return u;
  endfunction

endpackage

// File: rtl/fold_flag_gen.sv
// Row-to-row differences, threshold flags and dilation for one captured column.
// Latency: flags and sign bits are registered one cycle after the column settles.
// No backpressure: recomputes every cycle from the held column and threshold.
module fold_flag_gen
  import fold_pkg::*;
#(
  parameter int ROWS   = 19,
  parameter int DATA_W = 16,
  parameter int RADIUS = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS-1:0][DATA_W-1:0]    col_i,
  input  logic [DATA_W-1:0]              thresh_i,
  output logic [ROWS-1:0]                flag_o,
  output logic [ROWS-1:0]                neg_o
);

  logic [ROWS-1:0] t_w;
  logic [ROWS-1:0] f_d;
  logic [ROWS-1:0] neg_d;

  // Full-precision differences (DATA_W+1 bits never wrap) and threshold test.
  always_comb begin
    logic [DATA_W:0]        d;
    logic signed [MAX_W:0]  dx;
    t_w   = '0;
    neg_d = '0;
    d     = '0;
    dx    = '0;
    for (int n = 1; n < ROWS; n++) begin
      d        = {col_i[n][DATA_W-1], col_i[n]} - {col_i[n-1][DATA_W-1], col_i[n-1]};
      dx       = signed'({{(MAX_W-DATA_W){d[DATA_W]}}, d});
      t_w[n]   = abs_diff(dx) >= {{(MAX_W+1-DATA_W){1'b0}}, thresh_i};
      neg_d[n] = d[DATA_W];
    end
    // Row 0 has a zero difference, so it only trips on a zero threshold.
    t_w[0] = (thresh_i == '0);
  end

  // Dilate each flag across +/-RADIUS rows; rows beyond the column read as 0.
  always_comb begin
    f_d = '0;
    for (int n = 0; n < ROWS; n++) begin
      for (int k = -RADIUS; k <= RADIUS; k++) begin
        if ((n + k >= 0) && (n + k < ROWS)) begin
          f_d[n] = f_d[n] | t_w[n+k];
        end
      end
    end
  end

  // Register flags and difference signs for the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_o <= '0;
      neg_o  <= '0;
    end else begin
      flag_o <= f_d;
      neg_o  <= neg_d;
    end
  end

endmodule

// File: rtl/fold_remover_scan.sv
// Fold remover: flags steep row steps, dilates them, clamps each flagged run.
// Latency: out_valid ROWS+1 cycles after capture; one column per ROWS+1 cycles.
// Backpressure: in_ready is low for the whole scan; in_valid while busy is ignored.
// Optional FOLD_REMOVER_STATS_EN adds fold_count and fold_rows outputs.
module fold_remover_scan
  import fold_pkg::*;
#(
  parameter int ROWS          = 19,
  parameter int DATA_W        = 16,
  parameter int RADIUS        = 1,
  parameter int FILL_MAG      = 1000,
  parameter int TAIL_FILL_ALL = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [ROWS-1:0][DATA_W-1:0]  in,
  input  logic [DATA_W-1:0]                   thresh,
  output logic                                out_valid,
  output logic signed [ROWS-1:0][DATA_W-1:0]  out,
  output logic                                busy
`ifdef FOLD_REMOVER_STATS_EN
  ,
  output logic [$clog2(ROWS+1)-1:0]           fold_count,
  output logic [ROWS-1:0]                     fold_rows
`endif
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(ROWS+1);
  localparam logic [DATA_W-1:0] NEG_FILL = DATA_W'(-FILL_MAG);
  localparam logic [DATA_W-1:0] POS_FILL = DATA_W'(FILL_MAG);

  scan_state_e                  state_q, nxt_state;
  logic [IDX_W-1:0]             idx_q;
  logic                         prime_q;
  logic [ROWS-1:0][DATA_W-1:0]  col_q, work_q, work_d, out_q;
  logic [DATA_W-1:0]            thresh_q;
  logic                         out_valid_q, in_ready_q, busy_q;
  logic [ROWS-1:0]              flag_w, neg_w;
  logic                         last_row, row_flag, open_fold, fill_all;
  logic [DATA_W-1:0]            row_val;
`ifdef FOLD_REMOVER_STATS_EN
  logic [CNT_W-1:0]             cnt_q, cnt_d, fold_count_q;
  logic [ROWS-1:0]              mask_q, mask_d, fold_rows_q;
`endif

  fold_flag_gen #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .RADIUS (RADIUS)
  ) u_flag_gen (
    .clk      (clk),
    .rst      (reset),
    .col_i    (col_q),
    .thresh_i (thresh_q),
    .flag_o   (flag_w),
    .neg_o    (neg_w)
  );

  // Per-row decision for the row under the scan pointer.
  always_comb begin
    last_row  = (idx_q == IDX_W'(ROWS-1));
    row_flag  = flag_w[idx_q];
    row_val   = col_q[idx_q];
    open_fold = 1'b0;
    fill_all  = 1'b0;
    nxt_state = state_q;
    case (state_q)
      SCAN_CLEAR: begin
        if (row_flag) begin
          open_fold = 1'b1;
          if (!last_row) begin
            row_val   = NEG_FILL;
            nxt_state = SCAN_FOLD;
          end else begin
            // Lone flag on the last row: clamp against the step direction.
            row_val = neg_w[idx_q] ? POS_FILL : NEG_FILL;
          end
        end
      end
      SCAN_FOLD: begin
        if (row_flag) begin
          row_val  = NEG_FILL;
          fill_all = last_row && (TAIL_FILL_ALL != 0);
        end else begin
          nxt_state = SCAN_CLEAR;
        end
      end
      default: ;
    endcase
    work_d        = work_q;
    work_d[idx_q] = row_val;
    if (fill_all) begin
      work_d = {ROWS{NEG_FILL}};
    end
`ifdef FOLD_REMOVER_STATS_EN
    mask_d        = mask_q;
    mask_d[idx_q] = row_flag;
    if (fill_all) begin
      mask_d = '1;
    end
    cnt_d = cnt_q + CNT_W'(open_fold);
`endif
  end

  // Capture, one-row-per-cycle scan, and publish of the finished column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      prime_q     <= 1'b0;
      col_q       <= '0;
      thresh_q    <= '0;
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FOLD_REMOVER_STATS_EN
      cnt_q        <= '0;
      mask_q       <= '0;
      fold_count_q <= '0;
      fold_rows_q  <= '0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            col_q      <= in;
            thresh_q   <= thresh;
            idx_q      <= '0;
            prime_q    <= 1'b1;
            state_q    <= SCAN_CLEAR;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FOLD_REMOVER_STATS_EN
            cnt_q  <= '0;
            mask_q <= '0;
`endif
          end
        end
        default: begin
          // First cycle after capture only waits for the flags to register.
          if (prime_q) begin
            prime_q <= 1'b0;
          end else begin
            work_q <= work_d;
`ifdef FOLD_REMOVER_STATS_EN
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
`endif
            if (last_row) begin
              out_q       <= work_d;
              out_valid_q <= 1'b1;
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
`ifdef FOLD_REMOVER_STATS_EN
              fold_count_q <= cnt_d;
              fold_rows_q  <= mask_d;
`endif
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= nxt_state;
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;
`ifdef FOLD_REMOVER_STATS_EN
  assign fold_count = fold_count_q;
  assign fold_rows  = fold_rows_q;
`endif

endmodule

// File: tb/tb_fold_remover_scan.sv
// Directed bench: three instances (RADIUS=1/TAIL_FILL_ALL=1, RADIUS=0, TAIL_FILL_ALL=0)
// share one stimulus stream; expected columns are written out by hand.
module tb_fold_remover_scan;

  localparam int ROWS = 10;
  localparam int DW   = 16;
  localparam int CW   = $clog2(ROWS+1);

  typedef logic [ROWS-1:0][DW-1:0] col_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  col_t in_col = '0;
  logic [DW-1:0] thresh = 16'd512;

  logic rdy_a, ov_a, busy_a, rdy_b, ov_b, busy_b, rdy_c, ov_c, busy_c;
  col_t out_a, out_b, out_c;
`ifdef FOLD_REMOVER_STATS_EN
  logic [CW-1:0]   cnt_a, cnt_b, cnt_c;
  logic [ROWS-1:0] rows_a, rows_b, rows_c;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fold_remover_scan #(.ROWS(ROWS), .DATA_W(DW), .RADIUS(1), .FILL_MAG(1000), .TAIL_FILL_ALL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .in(in_col),
    .thresh(thresh), .out_valid(ov_a), .out(out_a), .busy(busy_a)
`ifdef FOLD_REMOVER_STATS_EN
    , .fold_count(cnt_a), .fold_rows(rows_a)
`endif
  );

  fold_remover_scan #(.ROWS(ROWS), .DATA_W(DW), .RADIUS(0), .FILL_MAG(1000), .TAIL_FILL_ALL(1)) dut_r0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in(in_col),
    .thresh(thresh), .out_valid(ov_b), .out(out_b), .busy(busy_b)
`ifdef FOLD_REMOVER_STATS_EN
    , .fold_count(cnt_b), .fold_rows(rows_b)
`endif
  );

  fold_remover_scan #(.ROWS(ROWS), .DATA_W(DW), .RADIUS(1), .FILL_MAG(1000), .TAIL_FILL_ALL(0)) dut_t0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c), .in(in_col),
    .thresh(thresh), .out_valid(ov_c), .out(out_c), .busy(busy_c)
`ifdef FOLD_REMOVER_STATS_EN
    , .fold_count(cnt_c), .fold_rows(rows_c)
`endif
  );

  task automatic check(input string tag, input logic [ROWS*DW-1:0] got, input logic [ROWS*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic col_t mk(input int v [ROWS]);
    col_t c;
    for (int i = 0; i < ROWS; i++) c[i] = DW'(v[i]);
    return c;
  endfunction

  // Send one column, measure latency to out_valid on the first instance,
  // confirm in_ready stays low until completion and the pulse lasts one cycle.
  task automatic run_col(input col_t c, input bit junk);
    int lat;
    bit early;
    in_col = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    early = rdy_a;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (junk) begin
        in_valid = (k == 3);
        if (k == 3) in_col = ~c;
      end
      if (ov_a) lat = k;
      else if (rdy_a) early = 1'b1;
    end
    in_valid = 1'b0;
    check("latency", (ROWS*DW)'(lat), (ROWS*DW)'(11));
    check("rdy_low", (ROWS*DW)'(early), (ROWS*DW)'(0));
    check("rdy_back", (ROWS*DW)'(rdy_a), (ROWS*DW)'(1));
    @(posedge clk); #1;
    check("pulse_end", (ROWS*DW)'({ov_a, busy_a}), (ROWS*DW)'(0));
  endtask

  initial begin
    int seen;
    col_t zero = '0;
    col_t all_neg = mk('{-1000,-1000,-1000,-1000,-1000,-1000,-1000,-1000,-1000,-1000});

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out_a, zero);
    check("rst_flags", (ROWS*DW)'({ov_a, busy_a, rdy_a}), (ROWS*DW)'(3'b001));
    reset = 1'b0;
    @(posedge clk); #1;

    // Flat column passes through untouched.
    run_col(mk('{100,100,100,100,100,100,100,100,100,100}), 1'b0);
    check("flat", out_a, mk('{100,100,100,100,100,100,100,100,100,100}));

    // Step up at row 3, down at row 6: dilated flags cover rows 2..7.
    run_col(mk('{0,0,0,600,600,600,0,0,0,0}), 1'b0);
    check("plateau_r1", out_a, mk('{0,0,-1000,-1000,-1000,-1000,-1000,-1000,0,0}));
    check("plateau_t0", out_c, mk('{0,0,-1000,-1000,-1000,-1000,-1000,-1000,0,0}));
    check("plateau_r0", out_b, mk('{0,0,0,-1000,600,600,-1000,0,0,0}));
`ifdef FOLD_REMOVER_STATS_EN
    check("cnt_plateau_r1", (ROWS*DW)'(cnt_a), (ROWS*DW)'(1));
    check("mask_plateau_r1", (ROWS*DW)'(rows_a), (ROWS*DW)'(10'h0FC));
    check("cnt_plateau_r0", (ROWS*DW)'(cnt_b), (ROWS*DW)'(2));
`endif

    // Lone negative step on the last row.
    run_col(mk('{0,0,0,0,0,0,0,0,0,-700}), 1'b0);
    check("last_r0", out_b, mk('{0,0,0,0,0,0,0,0,0,1000}));
    check("last_r1", out_a, all_neg);
    check("last_t0", out_c, mk('{0,0,0,0,0,0,0,0,-1000,-1000}));

    // Fold opens at row 7 and is still open at row 9.
    run_col(mk('{0,0,0,0,0,0,0,0,600,600}), 1'b0);
    check("tail_all", out_a, all_neg);
    check("tail_part", out_c, mk('{0,0,0,0,0,0,0,-1000,-1000,-1000}));

    // Extreme step: |D| = 65535 must not wrap; a second in_valid mid-scan is ignored.
    run_col(mk('{0,0,0,0,-32768,32767,32767,32767,32767,32767}), 1'b1);
    check("extreme", out_a, mk('{0,0,0,-1000,-1000,-1000,-1000,32767,32767,32767}));

    // Reset while row 4 is being scanned abandons the column.
    in_col = mk('{0,0,0,600,600,600,0,0,0,0});
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out", out_a, zero);
    check("mid_rst_flags", (ROWS*DW)'({ov_a, busy_a, rdy_a}), (ROWS*DW)'(3'b001));
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_rdy", (ROWS*DW)'(rdy_a), (ROWS*DW)'(1));
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ov_a || ov_b || ov_c) seen++;
    end
    check("no_valid_after_rst", (ROWS*DW)'(seen), (ROWS*DW)'(0));
    check("out_still_zero", out_a, zero);

    // Next column after reset behaves normally.
    run_col(mk('{0,0,0,0,0,0,0,0,600,600}), 1'b0);
    check("post_rst_t0", out_c, mk('{0,0,0,0,0,0,0,-1000,-1000,-1000}));
    check("post_rst_r1", out_a, all_neg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
